// File: rtl/button_pio_in_if.sv
// Avalon-MM slave bus for button_pio_in: register access plus the interrupt line.
interface button_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/button_pio_in.sv
// Avalon-MM input PIO for buttons/switches: sync, optional debounce, edge capture, maskable irq.
// Define BUTTON_PIO_DEBOUNCE_EN to add per-bit debounce counters.
module button_pio_in #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = WIDTH'(4'hF),
  parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  button_pio_in_if.slave        bus,
  input  logic [WIDTH-1:0]      in_port
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clear;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Each bit owns its counter; a bounce back to the accepted level restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        level <= IDLE_LEVEL[i];
      end else if (sync2[i] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2[i];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign stable[i] = level;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= IDLE_LEVEL;
    end else begin
      stable <= sync2;
    end
  end
`endif

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    detect = '0;
    case (EDGE_TYPE)
      0:       detect = rise;
      1:       detect = fall;
      default: detect = rise | fall;
    endcase
  end

  assign clear = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Set is OR'd in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= IDLE_LEVEL;
      irqmask      <= '0;
      edge_capture <= '0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~clear) | detect;
      if (wr_en && bus.address == 2'd2) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = stable;
      2'd2:    bus.readdata[WIDTH-1:0] = irqmask;
      2'd3:    bus.readdata[WIDTH-1:0] = edge_capture;
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_capture & irqmask);

endmodule

// File: tb/tb_button_pio_in.sv
// Directed testbench for button_pio_in: falling-edge instance plus an any-edge instance.
module tb_button_pio_in;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int LAT   = 10;
  localparam int PULSE = 12;
`else
  localparam int LAT   = 3;
  localparam int PULSE = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_port;
  logic [3:0]  in2;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  button_pio_in_if bus ();
  button_pio_in_if bus2 ();

  button_pio_in #(
    .WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .in_port(in_port)
  );

  button_pio_in #(
    .WIDTH(4), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(8)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input bit which, input logic [1:0] a, output logic [31:0] v);
    if (which) begin
      bus2.address = a;
      #1;
      v = bus2.readdata;
    end else begin
      bus.address = a;
      #1;
      v = bus.readdata;
    end
  endtask

  task automatic wr(input bit which, input logic [1:0] a, input logic [31:0] v);
    if (which) begin
      bus2.address = a; bus2.writedata = v; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
    end else begin
      bus.address = a; bus.writedata = v; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_port = 4'hF; in2 = 4'hF;
    step(2);
    reset = 1'b0;
    rd(0, 2'd0, d); checks++;
    if (d !== 32'h0000000F) begin errors++; $display("FAIL reset_data: got %h expected %h", d, 32'hF); end
    rd(0, 2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected %h", d, 32'h0); end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_capture: got %h expected %h", d, 32'h0); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    rd(0, 2'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_reserved: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_falling_capture;
    in_port = 4'hE;
    step(LAT - 1);
    rd(0, 2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL fall_data_early: got %h expected %h", d, 32'hF); end
    step(1);
    rd(0, 2'd0, d); checks++;
    if (d !== 32'hE) begin errors++; $display("FAIL fall_data: got %h expected %h", d, 32'hE); end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL fall_capture_early: got %h expected %h", d, 32'h0); end
    step(1);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL fall_capture: got %h expected %h", d, 32'h1); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b expected 0", bus.irq); end
    wr(0, 2'd2, 32'h1);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL fall_irq_unmasked: got %b expected 1", bus.irq); end
    rd(0, 2'd2, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL mask_readback: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_w1c;
    in_port = 4'hA;
    step(LAT + 1);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h5) begin errors++; $display("FAIL w1c_setup: got %h expected %h", d, 32'h5); end
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL w1c_partial: got %h expected %h", d, 32'h1); end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_held: got %b expected 1", bus.irq); end
    wr(0, 2'd3, 32'h1);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_full: got %h expected %h", d, 32'h0); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b expected 0", bus.irq); end
  endtask

  task automatic test_collision;
    wr(0, 2'd2, 32'h2);
    in_port = 4'h8;
    step(LAT);
    wr(0, 2'd3, 32'h2);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL collide_capture: got %h expected %h", d, 32'h2); end
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", bus.irq); end
    wr(0, 2'd2, 32'h0);
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL mask_off_irq: got %b expected 0", bus.irq); end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL mask_keeps_capture: got %h expected %h", d, 32'h2); end
    wr(0, 2'd2, 32'h2);
    checks++;
    if (bus.irq !== 1'b1) begin errors++; $display("FAIL mask_on_irq: got %b expected 1", bus.irq); end
    wr(0, 2'd3, 32'hFFFF_FFFF);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL collide_cleanup: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reg_map;
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_write: got %h expected %h", d, 32'h0); end
    wr(0, 2'd0, 32'h0);
    rd(0, 2'd0, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL data_write_ignored: got %h expected %h", d, 32'h8); end
    bus.address = 2'd2; bus.writedata = 32'hF; bus.chipselect = 1'b0; bus.write_n = 1'b0;
    step(1);
    bus.chipselect = 1'b1; bus.write_n = 1'b1;
    step(1);
    bus.chipselect = 1'b0;
    rd(0, 2'd2, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL no_strobe_write: got %h expected %h", d, 32'h2); end
    wr(0, 2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL mask_upper_zero: got %h expected %h", d, 32'hF); end
    wr(0, 2'd2, 32'h0);
  endtask

  task automatic test_rise_ignored;
    in_port = 4'hF;
    step(LAT + 2);
    rd(0, 2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("FAIL rise_data: got %h expected %h", d, 32'hF); end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rise_not_captured: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid;
    in_port = 4'hE;
    step(LAT + 1);
    wr(0, 2'd2, 32'h1);
    in_port = 4'hF;
    step(LAT + 2);
    in_port = 4'hE;
    step(1);
    reset = 1'b1; in_port = 4'hF;
    step(1);
    reset = 1'b0;
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_capture: got %h expected %h", d, 32'h0); end
    rd(0, 2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_mask: got %h expected %h", d, 32'h0); end
    checks++;
    if (bus.irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", bus.irq); end
    step(LAT + 2);
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_pending: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_any_edge;
    in2 = 4'h7;
    step(LAT + 1);
    rd(1, 2'd3, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL any_fall: got %h expected %h", d, 32'h8); end
    step(PULSE - LAT - 1);
    in2 = 4'hF;
    wr(1, 2'd3, 32'h8);
    rd(1, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL any_clear: got %h expected %h", d, 32'h0); end
    step(LAT - 1);
    rd(1, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL any_rise_early: got %h expected %h", d, 32'h0); end
    step(1);
    rd(1, 2'd3, d); checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL any_rise: got %h expected %h", d, 32'h8); end
    checks++;
    if (bus2.irq !== 1'b0) begin errors++; $display("FAIL any_irq_masked: got %b expected 0", bus2.irq); end
  endtask

`ifdef BUTTON_PIO_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] exp;
    in_port = 4'hE;
    for (int i = 1; i <= 18; i++) begin
      step(1);
      if (i == 5) in_port = 4'hF;
      if (i == 7) in_port = 4'hE;
      rd(0, 2'd0, d);
      exp = (i >= 17) ? 32'hE : 32'hF;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL debounce_data[%0d]: got %h expected %h", i, d, exp); end
    end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL debounce_capture: got %h expected %h", d, 32'h1); end
    in_port = 4'hF;
    step(12);
    wr(0, 2'd3, 32'hF);
    in_port = 4'hE;
    step(7);
    in_port = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      rd(0, 2'd0, d); checks++;
      if (d !== 32'hF) begin errors++; $display("FAIL glitch_data[%0d]: got %h expected %h", i, d, 32'hF); end
    end
    rd(0, 2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_capture: got %h expected %h", d, 32'h0); end
  endtask
`endif

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    test_reset;
    test_falling_capture;
    test_w1c;
    test_collision;
    test_reg_map;
    test_rise_ignored;
    test_reset_mid;
    test_any_edge;
`ifdef BUTTON_PIO_DEBOUNCE_EN
    test_debounce;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
